neuron_out_collector: RTL and testbench

- Downstream stage of a neuron: consumes the neuron's bit-serial OUT bundle (REQ/ACK/DATA, 8 bits, LSB first) and reassembles each frame into a parallel byte.
- Pushes each completed byte into a first-word-fall-through FIFO.
- Presents the FIFO on a valid/ready read port to the next layer or the host.
- Back-pressure: REQ is withheld while the FIFO is full.

---
 rtl/neuron_out_collector.sv | 151 +++++++++++++++
 tb/tb_neuron_out_collector.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_out_collector.sv
// Deserialises the neuron's bit-serial OUT frames (8 bits, LSB first) into bytes and queues them in a FWFT FIFO.
// Optional frame counter / spurious-ACK flag enabled by defining NEURON_OUT_COLLECTOR_FRAME_CNT_EN.
module neuron_out_collector #(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RST,
  output logic          IN_REQ,
  input  logic          IN_ACK,
  input  logic          IN_DATA,
  output logic          RD_VALID,
  input  logic          RD_READY,
  output logic [7:0]    RD_DATA,
  output logic [LW-1:0] FIFO_LEVEL,
`ifdef NEURON_OUT_COLLECTOR_FRAME_CNT_EN
  output logic [15:0]   FRAME_CNT,
  output logic          DROP_ERR,
`endif
  output logic          FULL
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RECV = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          in_req_q, in_req_d;
  // Seven bits suffice: the eighth bit is taken straight from IN_DATA on the final edge.
  logic [6:0]    sr_q, sr_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    mem_q [DEPTH];

  logic          push;
  logic          pop;
  logic [7:0]    push_data;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      in_req_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_req_q <= in_req_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (level_q < LW'(DEPTH)) state_d = ST_WAIT;
      ST_WAIT: if (IN_ACK) state_d = ST_RECV;
      ST_RECV: if (cnt_q == 3'd7) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath control
  always_comb begin
    in_req_d  = (state_d == ST_WAIT);
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_data = {IN_DATA, sr_q};
    unique case (state_q)
      ST_WAIT: begin
        if (IN_ACK) begin
          sr_d  = {IN_DATA, sr_q[6:1]};
          cnt_d = 3'd1;
        end
      end
      ST_RECV: begin
        sr_d  = {IN_DATA, sr_q[6:1]};
        cnt_d = cnt_q + 3'd1;
        push  = (cnt_q == 3'd7);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign pop = (level_q != '0) && RD_READY;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (!push && pop) level_d = level_q - LW'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; contents are only visible while level_q is non-zero.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign IN_REQ     = in_req_q;
  assign RD_VALID   = (level_q != '0);
  assign RD_DATA    = mem_q[rd_ptr_q];
  assign FIFO_LEVEL = level_q;
  assign FULL       = (level_q == LW'(DEPTH));

`ifdef NEURON_OUT_COLLECTOR_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  logic        drop_err_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      frame_cnt_q <= '0;
      drop_err_q  <= 1'b0;
    end else begin
      if (push) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (IN_ACK && (state_q != ST_WAIT)) drop_err_q <= 1'b1;
    end
  end

  assign FRAME_CNT = frame_cnt_q;
  assign DROP_ERR  = drop_err_q;
`endif

endmodule

// File: tb/tb_neuron_out_collector.sv
// Randomised self-checking bench for neuron_out_collector against a queue-based reference model.
module tb_neuron_out_collector;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_ack = 1'b0;
  logic          in_data = 1'b0;
  logic          rd_ready = 1'b0;
  logic          in_req;
  logic          rd_valid;
  logic [7:0]    rd_data;
  logic [LW-1:0] fifo_level;
  logic          full;
`ifdef NEURON_OUT_COLLECTOR_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
  logic          drop_err;
`endif

  neuron_out_collector #(.DEPTH(DEPTH)) dut (
    .CLK(clk),
    .RST(rst),
    .IN_REQ(in_req),
    .IN_ACK(in_ack),
    .IN_DATA(in_data),
    .RD_VALID(rd_valid),
    .RD_READY(rd_ready),
    .RD_DATA(rd_data),
    .FIFO_LEVEL(fifo_level),
`ifdef NEURON_OUT_COLLECTOR_FRAME_CNT_EN
    .FRAME_CNT(frame_cnt),
    .DROP_ERR(drop_err),
`endif
    .FULL(full)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  byte unsigned model_q[$];
  int          exp_frames = 0;
  bit          exp_drop = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fifo(input string tag);
    check_eq({tag, "_valid"}, {31'd0, rd_valid}, (model_q.size() > 0) ? 32'd1 : 32'd0);
    check_eq({tag, "_level"}, {29'd0, fifo_level}, model_q.size());
    check_eq({tag, "_full"}, {31'd0, full}, (model_q.size() == DEPTH) ? 32'd1 : 32'd0);
    if (model_q.size() > 0) check_eq({tag, "_data"}, {24'd0, rd_data}, {24'd0, model_q[0]});
`ifdef NEURON_OUT_COLLECTOR_FRAME_CNT_EN
    check_eq({tag, "_fcnt"}, {16'd0, frame_cnt}, exp_frames % 65536);
    check_eq({tag, "_drop"}, {31'd0, drop_err}, {31'd0, exp_drop});
`endif
  endtask

  task automatic send_frame(input byte unsigned b, input bit pop_last, input bit spurious);
    int waited = 0;
    while (!in_req && waited < 10) begin
      tick();
      waited++;
    end
    check_eq("req_before_frame", {31'd0, in_req}, 32'd1);
    if (!in_req) return;
    in_ack  = 1'b1;
    in_data = b[0];
    tick();
    in_ack = 1'b0;
    check_eq("req_after_ack", {31'd0, in_req}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      in_data = b[i];
      if (spurious && i == 3) begin
        in_ack   = 1'b1;
        exp_drop = 1'b1;
      end
      if (pop_last && i == 7) rd_ready = 1'b1;
      tick();
      in_ack = 1'b0;
    end
    rd_ready = 1'b0;
    if (pop_last && model_q.size() > 0) void'(model_q.pop_front());
    model_q.push_back(b);
    exp_frames++;
    check_fifo("frame");
    check_eq("req_after_frame", {31'd0, in_req}, 32'd0);
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    if (model_q.size() > 0) void'(model_q.pop_front());
    check_fifo("pop");
  endtask

  task automatic spurious_idle();
    in_ack  = 1'b1;
    in_data = 1'($urandom);
    tick();
    in_ack   = 1'b0;
    exp_drop = 1'b1;
    check_fifo("spur");
  endtask

  task automatic clear_model();
    model_q.delete();
    exp_frames = 0;
    exp_drop   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"}, {31'd0, in_req}, 32'd0);
    check_fifo(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    byte unsigned b;
    // Reset and idle
    rst = 1'b1;
    tick();
    clear_model();
    check_reset_outputs("reset");
    rst = 1'b0;
    check_eq("req_first_cycle", {31'd0, in_req}, 32'd0);
    tick();
    tick();
    check_eq("req_idle", {31'd0, in_req}, 32'd1);

    // Single frame 0x5A
    send_frame(8'h5A, 1'b0, 1'b0);
    pop_one();

    // Fill with no reads, then wrap-around drain
    send_frame(8'h01, 1'b0, 1'b0);
    send_frame(8'h7F, 1'b0, 1'b0);
    send_frame(8'h00, 1'b0, 1'b0);
    send_frame(8'h80, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("req_held_full", {31'd0, in_req}, 32'd0);
    end
    check_fifo("full");
    pop_one();
    tick();
    check_eq("req_after_pop", {31'd0, in_req}, 32'd1);
    send_frame(8'h33, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) pop_one();
    pop_one();

    // Push and pop on the same edge
    send_frame(8'hA5, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    pop_one();

    // Randomised traffic
    for (int n = 0; n < 40; n++) begin
      b = 8'($urandom);
      if (model_q.size() == DEPTH) pop_one();
      send_frame(b, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) spurious_idle();
      repeat ($urandom_range(0, 2)) pop_one();
    end

    // Reset in the middle of a frame
    if (model_q.size() == 0) send_frame(8'hC3, 1'b0, 1'b0);
    begin
      int waited = 0;
      while (!in_req && waited < 10) begin
        tick();
        waited++;
      end
    end
    check_eq("req_before_partial", {31'd0, in_req}, 32'd1);
    in_ack  = 1'b1;
    in_data = 1'b1;
    tick();
    in_ack = 1'b0;
    for (int i = 1; i < 4; i++) tick();
    rst = 1'b1;
    #1;
    clear_model();
    check_reset_outputs("midreset");
    tick();
    rst = 1'b0;
    tick();
    send_frame(8'h12, 1'b0, 1'b0);
    pop_one();

`ifdef NEURON_OUT_COLLECTOR_FRAME_CNT_EN
    rst = 1'b1;
    tick();
    clear_model();
    rst = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    send_frame(8'h44, 1'b1, 1'b0);
    check_eq("fcnt_three", {16'd0, frame_cnt}, 32'd3);
    check_eq("drop_clear", {31'd0, drop_err}, 32'd0);
    spurious_idle();
    tick();
    tick();
    check_eq("drop_sticky", {31'd0, drop_err}, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
